// File: rtl/ahb_bus_arbiter.sv
// AHB2 round-robin bus arbiter with burst, lock and RETRY/SPLIT/ERROR handling.
// Optional split masking is compiled in when AHB_ARB_SPLIT_EN is defined.
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic                   HREADY,
   input  logic [1:0]             HRESP,
`ifdef AHB_ARB_SPLIT_EN
   input  logic [NUM_MASTERS-1:0] HSPLIT,
`endif
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [3:0]             HMASTER,
   output logic                   HMASTLOCK
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;
   localparam logic [1:0] RSP_OKAY  = 2'd0;
   localparam logic [1:0] RSP_RETRY = 2'd2;
   localparam logic [1:0] RSP_SPLIT = 2'd3;

   typedef enum logic [1:0] {ARB, BURST, LOCKED, RESP} state_t;

   state_t                 state_reg, state_next;
   logic [3:0]             cnt_reg, cnt_next;
   logic [IW-1:0]          gnt_reg, gnt_next;
   logic [IW-1:0]          mst_reg;
   logic                   lock_reg;
   logic                   rearb;
   logic [IW-1:0]          rr_start;
   logic [NUM_MASTERS-1:0] elig_req;
`ifdef AHB_ARB_SPLIT_EN
   logic [NUM_MASTERS-1:0] mask_reg, mask_next, split_set;
`endif

   // First requester after 'start' in circular order; the start itself is checked last.
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                             input logic [IW-1:0] start);
      logic [IW-1:0] pick;
      logic [IW-1:0] cand;
      logic          found;
      int            j;
      pick  = DEF_IDX;
      found = 1'b0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         j = int'(start) + i;
         if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
         cand = IW'(j);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      gnt_next   = gnt_reg;
      rearb      = 1'b0;
      rr_start   = gnt_reg;
`ifdef AHB_ARB_SPLIT_EN
      split_set  = '0;
`endif
      if (HREADY) begin
         case (state_reg)
            ARB: begin
               if (lock_reg || HLOCK[gnt_reg]) begin
                  state_next = LOCKED;
               end else if (HTRANS == TR_NONSEQ && HBURST >= 3'd2) begin
                  state_next = BURST;
                  case (HBURST)
                     3'd2, 3'd3: cnt_next = 4'd3;
                     3'd4, 3'd5: cnt_next = 4'd7;
                     default:    cnt_next = 4'd15;
                  endcase
               end else begin
                  rearb = 1'b1;
               end
            end
            BURST: begin
               // The grant moves as the count reaches 1, i.e. visible during the last beat.
               if (HTRANS == TR_IDLE) begin
                  state_next = ARB;
                  cnt_next   = 4'd0;
                  rearb      = (cnt_reg != 4'd1);
               end else if (HTRANS == TR_SEQ) begin
                  cnt_next = cnt_reg - 4'd1;
                  rearb    = (cnt_reg == 4'd2);
                  if (cnt_reg <= 4'd1) begin
                     state_next = ARB;
                     cnt_next   = 4'd0;
                  end
               end
            end
            LOCKED: begin
               if (!HLOCK[mst_reg]) begin
                  state_next = ARB;
                  rearb      = 1'b1;
               end
            end
            default: begin
               state_next = ARB;
               cnt_next   = 4'd0;
               rearb      = 1'b1;
               if (HRESP == RSP_RETRY || HRESP == RSP_SPLIT) rr_start = mst_reg;
`ifdef AHB_ARB_SPLIT_EN
               if (HRESP == RSP_SPLIT && mst_reg != DEF_IDX) split_set[mst_reg] = 1'b1;
`endif
            end
         endcase
      end else if (HRESP != RSP_OKAY) begin
         state_next = RESP;
      end
`ifdef AHB_ARB_SPLIT_EN
      mask_next = (mask_reg & ~HSPLIT) | split_set;
      elig_req  = HBUSREQ & ~(mask_reg | split_set);
`else
      elig_req  = HBUSREQ;
`endif
      if (rearb) gnt_next = rr_pick(elig_req, rr_start);
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_reg <= ARB;
         cnt_reg   <= 4'd0;
         gnt_reg   <= DEF_IDX;
         mst_reg   <= DEF_IDX;
         lock_reg  <= 1'b0;
`ifdef AHB_ARB_SPLIT_EN
         mask_reg  <= '0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         gnt_reg   <= gnt_next;
`ifdef AHB_ARB_SPLIT_EN
         mask_reg  <= mask_next;
`endif
         if (HREADY) begin
            mst_reg  <= gnt_reg;
            lock_reg <= HLOCK[gnt_reg];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
         assign HGRANT[gi] = (gnt_reg == IW'(gi));
      end
   endgenerate

   assign HMASTER   = 4'(mst_reg);
   assign HMASTLOCK = lock_reg;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: per-cycle stimulus with hand-derived expected ownership.
module tb_ahb_bus_arbiter;

   logic       HCLK, HRESET;
   logic [3:0] HBUSREQ, HLOCK;
   logic [1:0] HTRANS;
   logic [2:0] HBURST;
   logic       HREADY;
   logic [1:0] HRESP;
   logic [3:0] HGRANT;
   logic [3:0] HMASTER;
   logic       HMASTLOCK;
`ifdef AHB_ARB_SPLIT_EN
   logic [3:0] HSPLIT;
`endif

   ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
      .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
`ifdef AHB_ARB_SPLIT_EN
      .HSPLIT(HSPLIT),
`endif
      .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
   );

   localparam logic [1:0] ID = 2'd0, BY = 2'd1, NS = 2'd2, SQ = 2'd3;
   localparam logic [1:0] OK = 2'd0, RT = 2'd2, SP = 2'd3;

   typedef struct {
      string      tag;
      logic [3:0] grant;
      logic [3:0] master;
      logic       lock;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle, queue the expected post-edge ownership, then pop and compare it.
   task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic [1:0] rsp, input logic [3:0] eg, input logic [3:0] em,
                       input logic el);
      exp_t e;
      @(negedge HCLK);
      HBUSREQ = req; HLOCK = lck; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp;
      sb.push_back('{tag, eg, em, el});
      @(posedge HCLK);
      #1;
      e = sb.pop_front();
      check({e.tag, ".grant"}, 32'(HGRANT), 32'(e.grant));
      check({e.tag, ".master"}, 32'(HMASTER), 32'(e.master));
      check({e.tag, ".lock"}, 32'(HMASTLOCK), 32'(e.lock));
      $display("step %-10s req=%b grant=%b master=%0d lock=%b", e.tag, req, HGRANT, HMASTER, HMASTLOCK);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESET = 1'b1; HBUSREQ = 4'b0; HLOCK = 4'b0; HTRANS = ID; HBURST = 3'd0;
      HREADY = 1'b1; HRESP = OK;
`ifdef AHB_ARB_SPLIT_EN
      HSPLIT = 4'b0;
`endif
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      HRESET = 1'b0;
      #1;
      check("rst.grant", 32'(HGRANT), 32'h1);
      check("rst.master", 32'(HMASTER), 32'h0);
      check("rst.lock", 32'(HMASTLOCK), 32'h0);

      // Round robin over M1..M3 with single transfers and one wait state
      step("rr1",   4'b1110, 4'b0, NS, 3'd0, 1'b1, OK, 4'b0010, 4'd0, 1'b0);
      step("rr2",   4'b1110, 4'b0, NS, 3'd0, 1'b1, OK, 4'b0100, 4'd1, 1'b0);
      step("rr_wt", 4'b1110, 4'b0, NS, 3'd0, 1'b0, OK, 4'b0100, 4'd1, 1'b0);
      step("rr3",   4'b1110, 4'b0, NS, 3'd0, 1'b1, OK, 4'b1000, 4'd2, 1'b0);
      step("rr4",   4'b1110, 4'b0, NS, 3'd0, 1'b1, OK, 4'b0010, 4'd3, 1'b0);
      step("park1", 4'b0000, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0001, 4'd1, 1'b0);
      step("park2", 4'b0000, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0001, 4'd0, 1'b0);

      // INCR8 by M1; M2 requests at beat 2, M1 drops its request mid-burst, 3 BUSY cycles
      step("b_gnt", 4'b0010, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0010, 4'd0, 1'b0);
      step("b_own", 4'b0010, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("b1",    4'b0010, 4'b0, NS, 3'd5, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("b2",    4'b0110, 4'b0, SQ, 3'd5, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("b3",    4'b0110, 4'b0, SQ, 3'd5, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      for (int i = 0; i < 3; i++)
         step("b_busy", 4'b0100, 4'b0, BY, 3'd5, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("b4",    4'b0100, 4'b0, SQ, 3'd5, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("b5",    4'b0100, 4'b0, SQ, 3'd5, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("b6",    4'b0100, 4'b0, SQ, 3'd5, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("b7",    4'b0100, 4'b0, SQ, 3'd5, 1'b1, OK, 4'b0100, 4'd1, 1'b0);
      step("b8",    4'b0100, 4'b0, SQ, 3'd5, 1'b1, OK, 4'b0100, 4'd2, 1'b0);

      // Locked sequence by M3 while M0 requests
      step("l_gnt", 4'b1000, 4'b1000, ID, 3'd0, 1'b1, OK, 4'b1000, 4'd2, 1'b0);
      step("l_own", 4'b1001, 4'b1000, ID, 3'd0, 1'b1, OK, 4'b1000, 4'd3, 1'b1);
      for (int i = 0; i < 4; i++)
         step("l_single", 4'b1001, 4'b1000, NS, 3'd0, 1'b1, OK, 4'b1000, 4'd3, 1'b1);
      step("l_drop", 4'b1001, 4'b0000, NS, 3'd0, 1'b1, OK, 4'b0001, 4'd3, 1'b0);
      step("l_m0",   4'b0001, 4'b0000, NS, 3'd0, 1'b1, OK, 4'b0001, 4'd0, 1'b0);

      // Two-cycle RETRY to M1 in the middle of an INCR4, M2 waiting
      step("r_gnt",  4'b0010, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0010, 4'd0, 1'b0);
      step("r_own",  4'b0010, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("r_b1",   4'b0110, 4'b0, NS, 3'd3, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("r_b2",   4'b0110, 4'b0, SQ, 3'd3, 1'b1, OK, 4'b0010, 4'd1, 1'b0);
      step("r_rsp1", 4'b0110, 4'b0, SQ, 3'd3, 1'b0, RT, 4'b0010, 4'd1, 1'b0);
      step("r_rsp2", 4'b0110, 4'b0, ID, 3'd3, 1'b1, RT, 4'b0100, 4'd1, 1'b0);
      step("r_next", 4'b0100, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0100, 4'd2, 1'b0);
      step("r_m2",   4'b0100, 4'b0, NS, 3'd0, 1'b1, OK, 4'b0100, 4'd2, 1'b0);

      // SPLIT to M2 as the only requester
      step("s_rsp1", 4'b0100, 4'b0, NS, 3'd0, 1'b0, SP, 4'b0100, 4'd2, 1'b0);
`ifdef AHB_ARB_SPLIT_EN
      step("s_rsp2", 4'b0100, 4'b0, ID, 3'd0, 1'b1, SP, 4'b0001, 4'd2, 1'b0);
      step("s_mask", 4'b0100, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0001, 4'd0, 1'b0);
      @(negedge HCLK);
      HSPLIT = 4'b0100;
      step("s_hsplit", 4'b0100, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0001, 4'd0, 1'b0);
      HSPLIT = 4'b0000;
      step("s_regnt", 4'b0100, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0100, 4'd0, 1'b0);
`else
      step("s_rsp2", 4'b0100, 4'b0, ID, 3'd0, 1'b1, SP, 4'b0100, 4'd2, 1'b0);
`endif
      step("s_after", 4'b0100, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0100, 4'd2, 1'b0);

      // Asynchronous reset in the middle of a locked sequence
      step("x_gnt",  4'b1000, 4'b1000, ID, 3'd0, 1'b1, OK, 4'b1000, 4'd2, 1'b0);
      step("x_lock", 4'b1001, 4'b1000, NS, 3'd0, 1'b1, OK, 4'b1000, 4'd3, 1'b1);
      @(negedge HCLK);
      #2;
      HRESET = 1'b1;
      #1;
      check("xrst.grant", 32'(HGRANT), 32'h1);
      check("xrst.master", 32'(HMASTER), 32'h0);
      check("xrst.lock", 32'(HMASTLOCK), 32'h0);
      $display("step %-10s grant=%b master=%0d lock=%b", "x_async", HGRANT, HMASTER, HMASTLOCK);
      @(posedge HCLK);
      @(negedge HCLK);
      HRESET = 1'b0; HBUSREQ = 4'b0; HLOCK = 4'b0;
      step("x_post", 4'b0000, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0001, 4'd0, 1'b0);
      step("x_rr",   4'b0010, 4'b0, ID, 3'd0, 1'b1, OK, 4'b0010, 4'd0, 1'b0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
